// File: rtl/pcie_msg_sram_writer.sv
// Packs a framed 32-bit dword stream into 256-bit SRAM lines, writes them into
// a circular line buffer and publishes a committed write pointer plus a
// per-message descriptor once a message is completely in the SRAM.
module pcie_msg_sram_writer #(
  parameter int DATA_WIDTH    = 256,
  parameter int ADDR_WIDTH    = 10,
  parameter int DEPTH         = 1024,
  parameter int MAX_MSG_LINES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  output logic                  msg_valid,
  output logic [ADDR_WIDTH-1:0] msg_addr,
  output logic [15:0]           msg_len_dw,
  output logic                  err_overflow,
  output logic                  err_proto
);

  typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] MAX_L   = MAX_MSG_LINES[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

  state_t                state;
  logic                  active;
  logic [ADDR_WIDTH:0]   line_ptr;
  logic [ADDR_WIDTH:0]   msg_start;
  logic [DATA_WIDTH-1:0] pack;
  logic [2:0]            idx;
  logic [15:0]           dw_cnt;
  logic                  commit_pend;
  logic [ADDR_WIDTH:0]   pend_ptr;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [15:0]           pend_len;

  logic [ADDR_WIDTH:0]   used;
  logic                  full;
  logic                  acc;
  logic [ADDR_WIDTH:0]   cur_line;
  logic [ADDR_WIDTH:0]   msg_first;
  logic [2:0]            wr_idx;
  logic [DATA_WIDTH-1:0] line_data;
  logic [15:0]           new_cnt;
  logic                  line_done;
  logic                  overflow;

  // Occupancy and handshake; active keeps in_ready low in the cycle after reset
  always_comb begin
    used     = line_ptr - rd_ptr;
    full     = (used == DEPTH_L);
    in_ready = active && ((state == DROP) || !full);
    acc      = in_valid && in_ready;
  end

  // Next-line datapath: an sop restarts packing at the message start line
  always_comb begin
    cur_line  = (state == COLLECT && in_sop) ? msg_start : line_ptr;
    msg_first = in_sop ? cur_line : msg_start;
    wr_idx    = in_sop ? 3'd0 : idx;
    line_data = in_sop ? '0 : pack;
    line_data[{wr_idx, 5'd0} +: 32] = in_data;
    new_cnt   = (in_sop ? 16'd0 : dw_cnt) + 16'd1;
    line_done = (wr_idx == 3'd7) || in_eop;
    overflow  = (state == COLLECT) && !in_sop && (idx == 3'd0) &&
                ((line_ptr - msg_start) == MAX_L);
  end

  // Framing FSM, line packing, SRAM write and two-stage commit pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      active       <= 1'b0;
      line_ptr     <= '0;
      msg_start    <= '0;
      pack         <= '0;
      idx          <= '0;
      dw_cnt       <= '0;
      commit_pend  <= 1'b0;
      pend_ptr     <= '0;
      pend_addr    <= '0;
      pend_len     <= '0;
      wr_ptr       <= '0;
      sram_wen     <= 1'b0;
      sram_waddr   <= '0;
      sram_wdata   <= '0;
      msg_valid    <= 1'b0;
      msg_addr     <= '0;
      msg_len_dw   <= '0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      active       <= 1'b1;
      sram_wen     <= 1'b0;
      msg_valid    <= 1'b0;
      err_overflow <= 1'b0;
      err_proto    <= 1'b0;
      commit_pend  <= 1'b0;
      // Publish one cycle after the final line write so the line is in the SRAM
      if (commit_pend) begin
        wr_ptr     <= pend_ptr;
        msg_valid  <= 1'b1;
        msg_addr   <= pend_addr;
        msg_len_dw <= pend_len;
      end
      if (acc) begin
        if (state == DROP) begin
          if (in_eop) state <= IDLE;
        end else if (state == IDLE && !in_sop) begin
          err_proto <= 1'b1;
        end else if (overflow) begin
          err_overflow <= 1'b1;
          line_ptr     <= msg_start;
          idx          <= '0;
          pack         <= '0;
          dw_cnt       <= '0;
          state        <= in_eop ? IDLE : DROP;
        end else begin
          if (state == COLLECT && in_sop) err_proto <= 1'b1;
          msg_start <= msg_first;
          if (line_done) begin
            sram_wen   <= 1'b1;
            sram_waddr <= cur_line[ADDR_WIDTH-1:0];
            sram_wdata <= line_data;
            line_ptr   <= cur_line + ONE_L;
            idx        <= '0;
            pack       <= '0;
          end else begin
            line_ptr <= cur_line;
            idx      <= wr_idx + 3'd1;
            pack     <= line_data;
          end
          if (in_eop) begin
            commit_pend <= 1'b1;
            pend_ptr    <= cur_line + ONE_L;
            pend_addr   <= msg_first[ADDR_WIDTH-1:0];
            pend_len    <= new_cnt;
            dw_cnt      <= '0;
            state       <= IDLE;
          end else begin
            dw_cnt <= new_cnt;
            state  <= COLLECT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pcie_msg_sram_writer.sv
// Bench for pcie_msg_sram_writer: expected SRAM writes and commits are queued
// when messages are driven and compared as the DUT produces them.
module tb_pcie_msg_sram_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_sop;
  logic         in_eop;
  logic         sram_wen;
  logic [9:0]   sram_waddr;
  logic [255:0] sram_wdata;
  logic [10:0]  rd_ptr;
  logic [10:0]  wr_ptr;
  logic         msg_valid;
  logic [9:0]   msg_addr;
  logic [15:0]  msg_len_dw;
  logic         err_overflow;
  logic         err_proto;

  pcie_msg_sram_writer #(
    .DATA_WIDTH(256), .ADDR_WIDTH(10), .DEPTH(1024), .MAX_MSG_LINES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .msg_valid(msg_valid),
    .msg_addr(msg_addr), .msg_len_dw(msg_len_dw),
    .err_overflow(err_overflow), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]   addr;
    logic [255:0] data;
  } wr_t;
  typedef struct {
    logic [10:0] ptr;
    logic [9:0]  addr;
    logic [15:0] len;
  } cm_t;
  typedef struct {
    int unsigned ndw;
    logic [31:0] base;
    logic [10:0] exp_addr;
    logic [10:0] exp_wr;
  } vec_t;

  wr_t wq[$];
  cm_t cq[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_proto = 0;
  int unsigned n_ovf   = 0;
  logic [10:0] mdl_line;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard side: every write and commit must match the head of its queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_proto) n_proto++;
      if (err_overflow) n_ovf++;
      if (sram_wen) begin
        chk("write_expected", 256'(wq.size() != 0), 256'(1));
        if (wq.size() != 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("waddr", 256'(sram_waddr), 256'(w.addr));
          chk("wdata", sram_wdata, w.data);
        end
      end
      if (msg_valid) begin
        chk("commit_expected", 256'(cq.size() != 0), 256'(1));
        if (cq.size() != 0) begin
          cm_t c;
          c = cq.pop_front();
          chk("wr_ptr_at_commit", 256'(wr_ptr), 256'(c.ptr));
          chk("msg_addr", 256'(msg_addr), 256'(c.addr));
          chk("msg_len_dw", 256'(msg_len_dw), 256'(c.len));
        end
      end
    end
  end

  task automatic expect_msg(input logic [31:0] base, input int unsigned n,
                            input logic [10:0] start, input bit commit);
    int unsigned nl;
    nl = (n + 7) / 8;
    for (int unsigned j = 0; j < nl; j++) begin
      wr_t w;
      w.addr = 10'(start + 11'(j));
      w.data = '0;
      for (int unsigned k = 0; k < 8; k++)
        if (j * 8 + k < n) w.data[32*k +: 32] = base + 32'(j * 8 + k);
      wq.push_back(w);
    end
    if (commit) begin
      cm_t c;
      c.ptr  = start + 11'(nl);
      c.addr = start[9:0];
      c.len  = 16'(n);
      cq.push_back(c);
    end
  endtask

  // Drive one dword and hold it until accepted; called at posedge+1
  task automatic send_dw(input logic [31:0] d, input logic s, input logic e);
    int unsigned waited;
    logic r;
    waited   = 0;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      if (r) break;
      waited++;
      if (waited > 200) begin
        chk("ready_timeout", 256'(waited), 256'(0));
        break;
      end
    end
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic send_msg(input logic [31:0] base, input int unsigned n);
    for (int unsigned i = 0; i < n; i++)
      send_dw(base + 32'(i), i == 0, i == n - 1);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((wq.size() != 0 || cq.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 256'(wq.size() + cq.size()), 256'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic run_msg(input logic [31:0] base, input int unsigned n);
    rd_ptr = mdl_line;
    expect_msg(base, n, mdl_line, 1'b1);
    send_msg(base, n);
    drain();
    mdl_line = mdl_line + 11'((n + 7) / 8);
    chk("wr_ptr_after_msg", 256'(wr_ptr), 256'(mdl_line));
  endtask

  vec_t tbl[5];

  initial begin
    logic [10:0] start;
    int unsigned p0;
    tbl[0] = '{ndw: 16, base: 32'h1,   exp_addr: 11'd0, exp_wr: 11'd2};
    tbl[1] = '{ndw: 1,  base: 32'hA5,  exp_addr: 11'd2, exp_wr: 11'd3};
    tbl[2] = '{ndw: 9,  base: 32'h100, exp_addr: 11'd3, exp_wr: 11'd5};
    tbl[3] = '{ndw: 8,  base: 32'h200, exp_addr: 11'd5, exp_wr: 11'd6};
    tbl[4] = '{ndw: 7,  base: 32'h300, exp_addr: 11'd6, exp_wr: 11'd7};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    rd_ptr = '0; mdl_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 256'(in_ready), 256'(0));
    chk("rst_wr_ptr", 256'(wr_ptr), 256'(0));
    chk("rst_sram_wen", 256'(sram_wen), 256'(0));
    chk("rst_sram_wdata", sram_wdata, 256'(0));
    chk("rst_msg_valid", 256'(msg_valid), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table of basic messages
    for (int unsigned i = 0; i < 5; i++) begin
      rd_ptr = mdl_line;
      expect_msg(tbl[i].base, tbl[i].ndw, tbl[i].exp_addr, 1'b1);
      send_msg(tbl[i].base, tbl[i].ndw);
      drain();
      chk("tbl_wr_ptr", 256'(wr_ptr), 256'(tbl[i].exp_wr));
      mdl_line = tbl[i].exp_wr;
    end

    // Single dword latency: write at T+1, commit at T+2
    rd_ptr = mdl_line;
    expect_msg(32'h5A, 1, mdl_line, 1'b1);
    send_dw(32'h5A, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_sram_wen", 256'(sram_wen), 256'(1));
    chk("t1_msg_valid", 256'(msg_valid), 256'(0));
    @(negedge clk);
    chk("t2_msg_valid", 256'(msg_valid), 256'(1));
    chk("t2_wr_ptr", 256'(wr_ptr), 256'(8));
    @(posedge clk); #1;
    mdl_line = 11'd8;

    // Advance the line pointer to 1020 with ordinary traffic
    while (mdl_line < 11'd1020) begin
      int unsigned nl;
      nl = (1020 - int'(mdl_line) > 64) ? 64 : 1020 - int'(mdl_line);
      run_msg(32'h1000_0000 + 32'(mdl_line) * 8, nl * 8);
    end

    // Wrap across the end of the SRAM
    run_msg(32'h2000_0000, 48);
    chk("wrap_wr_ptr", 256'(wr_ptr), 256'(11'h402));

    // Full buffer stalls mid-message and resumes when rd_ptr advances
    start  = mdl_line;
    rd_ptr = mdl_line - 11'd1023;
    expect_msg(32'h3000_0000, 16, start, 1'b1);
    for (int unsigned i = 0; i < 8; i++) send_dw(32'h3000_0000 + 32'(i), i == 0, 1'b0);
    in_data = 32'h3000_0008; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("full_ready_low", 256'(in_ready), 256'(0));
    repeat (3) @(negedge clk);
    chk("full_ready_held", 256'(in_ready), 256'(0));
    @(posedge clk); #1 rd_ptr = rd_ptr + 11'd1;
    for (int unsigned i = 8; i < 16; i++) send_dw(32'h3000_0000 + 32'(i), 1'b0, i == 15);
    drain();
    mdl_line = start + 11'd2;
    chk("full_wr_ptr", 256'(wr_ptr), 256'(mdl_line));

    // Overflow: 65-line message is dropped on dword 513
    start  = mdl_line;
    rd_ptr = mdl_line;
    p0     = n_ovf;
    expect_msg(32'h4000_0000, 512, start, 1'b0);
    for (int unsigned i = 0; i < 512; i++) send_dw(32'h4000_0000 + 32'(i), i == 0, 1'b0);
    @(negedge clk);
    chk("ovf_not_yet", 256'(n_ovf), 256'(p0));
    @(posedge clk); #1;
    send_dw(32'h4000_0200, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovf_pulse", 256'(err_overflow), 256'(1));
    @(posedge clk); #1;
    for (int unsigned i = 513; i < 520; i++) send_dw(32'h4000_0000 + 32'(i), i == 515, i == 519);
    drain();
    chk("ovf_count", 256'(n_ovf), 256'(p0 + 1));
    chk("ovf_wr_ptr", 256'(wr_ptr), 256'(start));
    run_msg(32'h5000_0000, 8);
    chk("after_ovf_start", 256'(wr_ptr), 256'(start + 11'd1));

    // Framing errors
    rd_ptr = mdl_line;
    p0     = n_proto;
    send_dw(32'hBAD, 1'b0, 1'b0);
    @(negedge clk);
    chk("stray_proto", 256'(err_proto), 256'(1));
    @(posedge clk); #1;
    expect_msg(32'h700, 8, mdl_line, 1'b0);
    for (int unsigned i = 0; i < 10; i++) send_dw(32'h700 + 32'(i), i == 0, 1'b0);
    expect_msg(32'h800, 12, mdl_line, 1'b1);
    send_msg(32'h800, 12);
    drain();
    mdl_line = mdl_line + 11'd2;
    chk("abort_wr_ptr", 256'(wr_ptr), 256'(mdl_line));
    chk("abort_proto_count", 256'(n_proto), 256'(p0 + 2));
    for (int unsigned i = 0; i < 3; i++) send_dw(32'hE00 + 32'(i), i == 0, 1'b0);
    expect_msg(32'hC3, 1, mdl_line, 1'b1);
    send_dw(32'hC3, 1'b1, 1'b1);
    drain();
    mdl_line = mdl_line + 11'd1;
    chk("sop_eop_abort_wr_ptr", 256'(wr_ptr), 256'(mdl_line));
    chk("sop_eop_proto_count", 256'(n_proto), 256'(p0 + 3));

    // Reset mid-message
    for (int unsigned i = 0; i < 5; i++) send_dw(32'hF00 + 32'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wr_ptr", 256'(wr_ptr), 256'(0));
    chk("mid_rst_in_ready", 256'(in_ready), 256'(0));
    chk("mid_rst_sram_wdata", sram_wdata, 256'(0));
    chk("mid_rst_sram_waddr", 256'(sram_waddr), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mdl_line = '0;
    run_msg(32'h9000_0000, 8);

    chk("queues_empty", 256'(wq.size() + cq.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
